i2c_slave_regfile: RTL and testbench
====================================

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h70, 7-bit device address matched after START.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of 8-bit registers (2..256).
REQ-003 SHALL have parameter PTR_W, default 2, register pointer width (2^PTR_W >= NUM_REGS).
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  system clock, at least 8x SCL rate.
- reset  in  1  synchronous reset, active-high.
REQ-005 SHALL have these ports:
- en  in  1  block enable.
- scl_i  in  1  raw SCL.
- sda_i  in  1  raw SDA.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- meas_we  in  1  host write strobe.
- meas_addr  in  PTR_W  host register index.
- meas_data  in  8  host write data.
- wr_valid  out  1  one-cycle pulse on each I2C register write.
- wr_addr  out  PTR_W  register index of that write.
- wr_data  out  8  data of that write.
- busy  out  1  high from an address-matched START until STOP or abort.

Function
REQ-006 SHALL synchronise scl_i and sda_i through 2 flops; all decoding SHALL use the synchronised values; SCL rise/fall SHALL be detected as 1-cycle events.
REQ-007 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-008 SHALL implement the states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-009 Data bits SHALL be sampled on SCL rise, MSB first; sda_oe SHALL change only on the clk cycle after an SCL fall.
REQ-010 ADDR: after 8 bits, a 7-bit match SHALL go to ADDR_ACK with the R/W bit latched; a mismatch SHALL go to IGNORE with sda_oe held at 0.
REQ-011 ADDR_ACK SHALL drive sda_oe=1 for one SCL period. Then W goes to PTR; R goes to RDATA using the current pointer.
REQ-012 PTR SHALL load the pointer from the byte.
- Value < NUM_REGS: ACK, then go to WDATA.
- Otherwise: NACK (sda_oe=0), then go to IGNORE; the pointer is unchanged.
REQ-013 WDATA: after 8 bits, the register SHALL be written and wr_valid pulse once with wr_addr=pointer and wr_data=byte; then ACK and go to WDATA (pointer increments).
REQ-014 RDATA: the register[pointer] byte SHALL be latched at entry; sda_oe SHALL equal the inverse of the current bit.
REQ-015 RDATA_ACK SHALL release SDA and sample the master's bit.
- ACK (0): increment the pointer and return to RDATA.
- NACK (1): go to IGNORE.
REQ-016 Pointer increment SHALL wrap from NUM_REGS-1 to 0.
REQ-017 A START in any state SHALL go to ADDR (repeated start), keeping the pointer.
REQ-018 A STOP in any state SHALL go to IDLE with sda_oe=0; busy SHALL clear the next cycle.
REQ-019 meas_we SHALL write meas_data to register[meas_addr] in one cycle. If it coincides with an I2C write to the same index, the I2C write SHALL win.
REQ-020 en=0 SHALL force IDLE and sda_oe=0; registers SHALL hold their values.

Reset
REQ-021 Reset SHALL set: state=IDLE, pointer=0, all registers=8'h00, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, synchronisers=1.
REQ-022 Reset asserted mid-transfer SHALL abort it within one cycle; no wr_valid SHALL be issued for the partial byte.

Configuration
REQ-023 With macro I2C_SLAVE_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow each synchroniser. This rejects pulses of 1 clk or shorter and adds 2 clk of latency.
REQ-024 Without I2C_SLAVE_GLITCH_FILTER_EN, there SHALL be no filter and latency SHALL be 2 clk from pin to decode.

Verification
REQ-025 Write sequence: START, 0xE0, 0x01, 0xB2, STOP -> three ACKs; wr_valid once with wr_addr=1 and wr_data=0xB2; register[1]=0xB2.
REQ-026 Read sequence: host loads reg0=0xF0 and reg1=0x0F; then START, 0xE0, 0x00, repeated START, 0xE1, read 2 bytes (master ACK, then NACK), STOP -> 0xF0 then 0x0F returned; state=IDLE.
REQ-027 Wrap: write burst at pointer 3 of 0x11, 0x22 -> reg3=0x11, reg0=0x22.
REQ-028 Mismatch: START, 0xA0 -> NACK; sda_oe stays 0 until STOP; busy stays 0.
REQ-029 Bad pointer: START, 0xE0, 0x07 -> NACK on the pointer byte; no wr_valid.
REQ-030 Glitch: with I2C_SLAVE_GLITCH_FILTER_EN defined, a 1-clk SDA low pulse while SCL is high -> no START detected.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS 8-bit registers behind an auto-incrementing pointer.
// Optional SCL/SDA majority glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module i2c_slave_regfile #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h70,
   parameter int unsigned NUM_REGS   = 4,
   parameter int unsigned PTR_W      = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   input  logic             meas_we,
   input  logic [PTR_W-1:0] meas_addr,
   input  logic [7:0]       meas_data,
   output logic             wr_valid,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
   logic w_scl, w_sda;
   logic r_scl_q, r_sda_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
      end else begin
         r_scl_s1 <= scl_i;
         r_scl_s2 <= r_scl_s1;
         r_sda_s1 <= sda_i;
         r_sda_s2 <= r_sda_s1;
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] r_scl_h, r_sda_h;
   logic       r_scl_f, r_sda_f;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Majority over the last three synchronised samples, registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_h <= 2'b11;
         r_sda_h <= 2'b11;
         r_scl_f <= 1'b1;
         r_sda_f <= 1'b1;
      end else begin
         r_scl_h <= {r_scl_h[0], r_scl_s2};
         r_sda_h <= {r_sda_h[0], r_sda_s2};
         r_scl_f <= maj3(r_scl_s2, r_scl_h[0], r_scl_h[1]);
         r_sda_f <= maj3(r_sda_s2, r_sda_h[0], r_sda_h[1]);
      end
   end

   assign w_scl = r_scl_f;
   assign w_sda = r_sda_f;
`else
   assign w_scl = r_scl_s2;
   assign w_sda = r_sda_s2;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_q <= 1'b1;
         r_sda_q <= 1'b1;
      end else begin
         r_scl_q <= w_scl;
         r_sda_q <= w_sda;
      end
   end

   logic w_scl_rise, w_scl_fall, w_start, w_stop;
   assign w_scl_rise = w_scl & ~r_scl_q;
   assign w_scl_fall = ~w_scl & r_scl_q;
   assign w_start    = r_scl_q & w_scl & r_sda_q & ~w_sda;
   assign w_stop     = r_scl_q & w_scl & ~r_sda_q & w_sda;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_cnt, w_cnt_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
   logic             r_rw, w_rw_nxt;
   logic             r_mack, w_mack_nxt;
   logic             r_sda_oe, w_sda_oe_nxt;
   logic             r_busy, w_busy_nxt;
   logic             w_i2c_we, w_ptr_ok;
   logic             r_wr_valid;
   logic [PTR_W-1:0] r_wr_addr;
   logic [7:0]       r_wr_data;
   logic [7:0]       r_regs [NUM_REGS];
   logic [7:0]       w_rd_cur, w_rd_next;

   assign w_ptr_inc = (32'(r_ptr) == NUM_REGS - 1) ? '0 : r_ptr + PTR_W'(1);
   assign w_ptr_ok  = 32'(r_shift) < NUM_REGS;
   assign w_rd_cur  = r_regs[r_ptr];
   assign w_rd_next = r_regs[w_ptr_inc];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_shift  <= '0;
         r_ptr    <= '0;
         r_rw     <= 1'b0;
         r_mack   <= 1'b1;
         r_sda_oe <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_shift  <= w_shift_nxt;
         r_ptr    <= w_ptr_nxt;
         r_rw     <= w_rw_nxt;
         r_mack   <= w_mack_nxt;
         r_sda_oe <= w_sda_oe_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   // Bits shift in on SCL rise; state and sda_oe move only on SCL fall.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_shift_nxt  = r_shift;
      w_ptr_nxt    = r_ptr;
      w_rw_nxt     = r_rw;
      w_mack_nxt   = r_mack;
      w_sda_oe_nxt = r_sda_oe;
      w_busy_nxt   = r_busy;
      w_i2c_we     = 1'b0;
      if (!en || w_stop) begin
         w_state_nxt  = IDLE;
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
      end else if (w_start) begin
         w_state_nxt  = ADDR;
         w_cnt_nxt    = '0;
         w_sda_oe_nxt = 1'b0;
      end else begin
         unique case (r_state)
            ADDR, PTR, WDATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt = {r_shift[6:0], w_sda};
                  w_cnt_nxt   = r_cnt + 4'd1;
               end else if (w_scl_fall && r_cnt == 4'd8) begin
                  w_cnt_nxt = '0;
                  if (r_state == ADDR) begin
                     if (r_shift[7:1] == SLAVE_ADDR) begin
                        w_state_nxt  = ADDR_ACK;
                        w_rw_nxt     = r_shift[0];
                        w_sda_oe_nxt = 1'b1;
                        w_busy_nxt   = 1'b1;
                     end else begin
                        w_state_nxt = IGNORE;
                     end
                  end else if (r_state == PTR) begin
                     // sda_oe doubles as the ACK/NACK decision for PTR_ACK.
                     w_state_nxt  = PTR_ACK;
                     w_sda_oe_nxt = w_ptr_ok;
                     if (w_ptr_ok) w_ptr_nxt = PTR_W'(r_shift);
                  end else begin
                     w_i2c_we     = 1'b1;
                     w_ptr_nxt    = w_ptr_inc;
                     w_state_nxt  = WDATA_ACK;
                     w_sda_oe_nxt = 1'b1;
                  end
               end
            end
            ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_cnt_nxt = '0;
                  if (r_rw) begin
                     w_state_nxt  = RDATA;
                     w_shift_nxt  = w_rd_cur;
                     w_sda_oe_nxt = ~w_rd_cur[7];
                  end else begin
                     w_state_nxt  = PTR;
                     w_sda_oe_nxt = 1'b0;
                  end
               end
            end
            PTR_ACK: begin
               if (w_scl_fall) begin
                  w_state_nxt  = r_sda_oe ? WDATA : IGNORE;
                  w_sda_oe_nxt = 1'b0;
               end
            end
            WDATA_ACK: begin
               if (w_scl_fall) begin
                  w_state_nxt  = WDATA;
                  w_sda_oe_nxt = 1'b0;
               end
            end
            RDATA: begin
               if (w_scl_rise) begin
                  w_cnt_nxt = r_cnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_cnt == 4'd8) begin
                     w_state_nxt  = RDATA_ACK;
                     w_cnt_nxt    = '0;
                     w_sda_oe_nxt = 1'b0;
                  end else begin
                     w_shift_nxt  = {r_shift[6:0], 1'b0};
                     w_sda_oe_nxt = ~r_shift[6];
                  end
               end
            end
            RDATA_ACK: begin
               if (w_scl_rise) begin
                  w_mack_nxt = w_sda;
               end else if (w_scl_fall) begin
                  if (!r_mack) begin
                     w_ptr_nxt    = w_ptr_inc;
                     w_state_nxt  = RDATA;
                     w_shift_nxt  = w_rd_next;
                     w_sda_oe_nxt = ~w_rd_next[7];
                  end else begin
                     w_state_nxt = IGNORE;
                  end
               end
            end
            IGNORE:  w_sda_oe_nxt = 1'b0;
            default: w_sda_oe_nxt = 1'b0;
         endcase
      end
   end

   // Host write first so a same-index I2C write overrides it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         if (meas_we) r_regs[meas_addr] <= meas_data;
         if (w_i2c_we) begin
            r_regs[r_ptr] <= r_shift;
            r_wr_addr     <= r_ptr;
            r_wr_data     <= r_shift;
         end
         r_wr_valid <= w_i2c_we;
      end
   end

   assign sda_oe   = r_sda_oe;
   assign busy     = r_busy;
   assign wr_valid = r_wr_valid;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master plus expected-value queues.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

   localparam int unsigned PTR_W = 2;
   localparam int          Q     = 4;

   logic             clk = 1'b0;
   logic             reset, en, scl, m_sda;
   logic             meas_we;
   logic [PTR_W-1:0] meas_addr;
   logic [7:0]       meas_data;
   logic             sda_oe, wr_valid, busy;
   logic [PTR_W-1:0] wr_addr;
   logic [7:0]       wr_data;
   logic             sda_line;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_q [$];
   logic [9:0] wr_q  [$];
   logic       mon_on = 1'b0;
   logic       saw_oe = 1'b0;
   logic       saw_busy = 1'b0;

   assign sda_line = m_sda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_regfile #(.SLAVE_ADDR(7'h70), .NUM_REGS(4), .PTR_W(PTR_W)) dut (
      .clk(clk), .reset(reset), .en(en), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
      .meas_we(meas_we), .meas_addr(meas_addr), .meas_data(meas_data),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_rstart();
      m_sda = 1'b1; tick(Q);
      scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(Q);
   endtask

   task automatic wbit(input logic b);
      m_sda = b; tick(Q);
      scl = 1'b1; tick(2 * Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic rbit(output logic b);
      m_sda = 1'b1; tick(Q);
      scl = 1'b1; tick(Q);
      b = sda_line; tick(Q);
      scl = 1'b0; tick(Q);
   endtask

   // Expected ACK line level (0 = ACK) is queued before the byte goes out.
   task automatic wbyte(input logic [7:0] d, input logic exp_nack, input string tag);
      logic a;
      exp_q.push_back({7'b0, exp_nack});
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(a);
      chk(tag, 16'({7'b0, a}), 16'(exp_q.pop_front()));
   endtask

   task automatic rbyte(input logic [7:0] exp, input logic mack, input string tag);
      logic [7:0] d;
      logic       b;
      exp_q.push_back(exp);
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
      wbit(mack);
      chk(tag, 16'(d), 16'(exp_q.pop_front()));
   endtask

   task automatic host_wr(input logic [PTR_W-1:0] a, input logic [7:0] d);
      meas_addr = a; meas_data = d; meas_we = 1'b1; tick(1);
      meas_we = 1'b0;
   endtask

   // Every wr_valid pulse must match the head of the expected-write queue.
   always @(negedge clk) begin
      logic [15:0] e;
      if (!reset && wr_valid === 1'b1) begin
         e = (wr_q.size() > 0) ? 16'(wr_q.pop_front()) : 16'hFFFF;
         chk("wr_valid", 16'({wr_addr, wr_data}), e);
      end
      if (mon_on && sda_oe !== 1'b0) saw_oe = 1'b1;
      if (mon_on && busy !== 1'b0) saw_busy = 1'b1;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; en = 1'b1; scl = 1'b1; m_sda = 1'b1;
      meas_we = 1'b0; meas_addr = '0; meas_data = '0;
      tick(4);
      chk("rst_sda_oe", 16'(sda_oe), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_wr_valid", 16'(wr_valid), 16'd0);
      chk("rst_wr_addr", 16'(wr_addr), 16'd0);
      chk("rst_wr_data", 16'(wr_data), 16'd0);
      reset = 1'b0;
      tick(4);

      // Write 0xB2 to register 1
      i2c_start();
      chk("busy_pre_match", 16'(busy), 16'd0);
      wbyte(8'hE0, 1'b0, "w_addr_ack");
      chk("busy_matched", 16'(busy), 16'd1);
      wbyte(8'h01, 1'b0, "w_ptr_ack");
      wr_q.push_back({2'd1, 8'hB2});
      wbyte(8'hB2, 1'b0, "w_data_ack");
      i2c_stop();
      tick(2);
      chk("busy_after_stop", 16'(busy), 16'd0);
      chk("oe_after_stop", 16'(sda_oe), 16'd0);

      i2c_start();
      wbyte(8'hE0, 1'b0, "rb_addr");
      wbyte(8'h01, 1'b0, "rb_ptr");
      i2c_rstart();
      wbyte(8'hE1, 1'b0, "rb_raddr");
      rbyte(8'hB2, 1'b1, "rb_reg1");
      i2c_stop();

      // Host-loaded registers read back through a repeated start
      host_wr(2'd0, 8'hF0);
      host_wr(2'd1, 8'h0F);
      i2c_start();
      wbyte(8'hE0, 1'b0, "r_addr");
      wbyte(8'h00, 1'b0, "r_ptr");
      i2c_rstart();
      wbyte(8'hE1, 1'b0, "r_raddr");
      rbyte(8'hF0, 1'b0, "r_byte0");
      rbyte(8'h0F, 1'b1, "r_byte1");
      i2c_stop();
      tick(2);
      chk("r_idle_busy", 16'(busy), 16'd0);
      chk("r_idle_oe", 16'(sda_oe), 16'd0);

      // Burst across the pointer wrap
      i2c_start();
      wbyte(8'hE0, 1'b0, "wr_addr");
      wbyte(8'h03, 1'b0, "wr_ptr");
      wr_q.push_back({2'd3, 8'h11});
      wbyte(8'h11, 1'b0, "wr_d0");
      wr_q.push_back({2'd0, 8'h22});
      wbyte(8'h22, 1'b0, "wr_d1");
      i2c_stop();
      i2c_start();
      wbyte(8'hE0, 1'b0, "wrr_addr");
      wbyte(8'h03, 1'b0, "wrr_ptr");
      i2c_rstart();
      wbyte(8'hE1, 1'b0, "wrr_raddr");
      rbyte(8'h11, 1'b0, "wrap_reg3");
      rbyte(8'h22, 1'b1, "wrap_reg0");
      i2c_stop();

      // Foreign address: never drive SDA, never go busy
      saw_oe = 1'b0; saw_busy = 1'b0; mon_on = 1'b1;
      i2c_start();
      wbyte(8'hA0, 1'b1, "mm_addr_nack");
      wbyte(8'h55, 1'b1, "mm_data_nack");
      i2c_stop();
      mon_on = 1'b0;
      chk("mm_sda_oe", 16'(saw_oe), 16'd0);
      chk("mm_busy", 16'(saw_busy), 16'd0);

      // Out-of-range pointer NACKs and leaves the pointer at 0
      i2c_start();
      wbyte(8'hE0, 1'b0, "bp_addr");
      wbyte(8'h07, 1'b1, "bp_ptr_nack");
      wbyte(8'h99, 1'b1, "bp_ignored");
      i2c_stop();
      i2c_start();
      wbyte(8'hE1, 1'b0, "bp_raddr");
      rbyte(8'h22, 1'b1, "bp_ptr_kept");
      i2c_stop();

      // Disable mid-transfer
      i2c_start();
      wbyte(8'hE0, 1'b0, "en_addr");
      chk("en_busy_on", 16'(busy), 16'd1);
      en = 1'b0;
      tick(2);
      chk("en_busy_off", 16'(busy), 16'd0);
      chk("en_oe_off", 16'(sda_oe), 16'd0);
      en = 1'b1;
      i2c_stop();
      i2c_start();
      wbyte(8'hE1, 1'b0, "en_raddr");
      rbyte(8'h22, 1'b1, "en_reg_hold");
      i2c_stop();

      // Reset in the middle of a data byte
      i2c_start();
      wbyte(8'hE0, 1'b0, "rm_addr");
      wbyte(8'h01, 1'b0, "rm_ptr");
      for (int i = 0; i < 5; i++) wbit(1'b1);
      reset = 1'b1;
      tick(1);
      chk("rm_busy", 16'(busy), 16'd0);
      chk("rm_oe", 16'(sda_oe), 16'd0);
      tick(2);
      reset = 1'b0;
      i2c_stop();
      i2c_start();
      wbyte(8'hE1, 1'b0, "rm_raddr");
      rbyte(8'h00, 1'b1, "rm_reg0_clr");
      i2c_stop();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      begin
         logic a;
         scl = 1'b1; m_sda = 1'b1; tick(Q);
         m_sda = 1'b0; tick(1);
         m_sda = 1'b1; tick(Q);
         scl = 1'b0; tick(Q);
         for (int i = 7; i >= 0; i--) wbit(1'(8'hE0 >> i));
         rbit(a);
         chk("glitch_no_start", 16'(a), 16'd1);
         chk("glitch_busy", 16'(busy), 16'd0);
         i2c_stop();
      end
`endif

      tick(4);
      chk("wr_missing", 16'(wr_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
